// File: rtl/friscv_cache_ways.sv
// rtl/friscv_cache_ways.sv - N-way set-associative cache storage with round-robin fill and flush engine
module friscv_cache_ways #(
    parameter int WLEN          = 32,
    parameter int ADDR_W        = 32,
    parameter int CACHE_BLOCK_W = 128,
    parameter int CACHE_DEPTH   = 512,
    parameter int NB_WAYS       = 2,
    localparam int WAY_W        = (NB_WAYS > 1) ? $clog2(NB_WAYS) : 1
)(
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       srst,
    input  logic                       flush_req,
    output logic                       ready,
    input  logic                       wen,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [CACHE_BLOCK_W-1:0]   wdata,
    input  logic [CACHE_BLOCK_W/8-1:0] wstrb,
    input  logic                       ren,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [WLEN-1:0]            rdata,
    output logic                       hit,
    output logic                       miss,
    output logic [WAY_W-1:0]           hit_way
);

    localparam int OFFSET_IX = (WLEN == 64) ? 3 : 2;
    localparam int NB_WORDS  = CACHE_BLOCK_W / WLEN;
    localparam int OFF_W     = $clog2(NB_WORDS);
    localparam int OFF_WS    = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W     = $clog2(CACHE_DEPTH);
    localparam int IDX_LSB   = OFFSET_IX + OFF_W;
    localparam int TAG_LSB   = IDX_LSB + IDX_W;
    localparam int TAG_W     = ADDR_W - TAG_LSB;
    localparam int NB_BYTES  = CACHE_BLOCK_W / 8;

    typedef enum logic {FLUSH, IDLE} state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              counter_q, counter_d;
    logic [CACHE_DEPTH-1:0][WAY_W-1:0] ptr_q;

    logic [CACHE_BLOCK_W-1:0]      data_mem  [NB_WAYS][CACHE_DEPTH];
    logic                          valid_mem [NB_WAYS][CACHE_DEPTH];
    logic [TAG_W-1:0]              tag_mem   [NB_WAYS][CACHE_DEPTH];

    logic                          hit_q, miss_q;
    logic [WLEN-1:0]               rdata_q;
    logic [WAY_W-1:0]              hit_way_q;

    logic [IDX_W-1:0]              w_idx, r_idx;
    logic [TAG_W-1:0]              w_tag, r_tag;
    logic [OFF_WS-1:0]             r_word;
    logic [WAY_W-1:0]              victim, victim_nxt, rd_way;
    logic                          do_flush, do_fill, do_read, rd_hit, dup_tag;
    logic [CACHE_BLOCK_W-1:0]      rd_line;
    logic [WLEN-1:0]               rd_word;
    logic                          unused_addr;

    assign w_idx  = waddr[IDX_LSB +: IDX_W];
    assign w_tag  = waddr[TAG_LSB +: TAG_W];
    assign r_idx  = raddr[IDX_LSB +: IDX_W];
    assign r_tag  = raddr[TAG_LSB +: TAG_W];
    assign r_word = (NB_WORDS > 1) ? raddr[OFFSET_IX +: OFF_WS] : '0;
    assign unused_addr = ^{waddr[IDX_LSB-1:0], raddr[OFFSET_IX-1:0]};

    // Requests are only honoured in IDLE; flush_req and srst win over a same-cycle access.
    assign ready    = (state_q == IDLE);
    assign do_flush = (state_q == FLUSH) && !srst;
    assign do_fill  = ready && !srst && !flush_req && wen;
    assign do_read  = ready && !srst && !flush_req && ren && !wen;

    assign victim     = ptr_q[w_idx];
    assign victim_nxt = (NB_WAYS == 1) ? '0 : victim + WAY_W'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= FLUSH;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        if (srst) begin
            state_d   = FLUSH;
            counter_d = '0;
        end else begin
            case (state_q)
                FLUSH: begin
                    counter_d = counter_q + IDX_W'(1);
                    if (counter_q == IDX_W'(CACHE_DEPTH - 1))
                        state_d = IDLE;
                end
                default: begin
                    if (flush_req) begin
                        state_d   = FLUSH;
                        counter_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q <= '0;
        end else if (do_flush) begin
            ptr_q[counter_q] <= '0;
        end else if (do_fill) begin
            ptr_q[w_idx] <= victim_nxt;
        end
    end

    for (genvar gw = 0; gw < NB_WAYS; gw++) begin : g_way
        always_ff @(posedge aclk) begin
            if (do_flush) begin
                valid_mem[gw][counter_q] <= 1'b0;
                tag_mem[gw][counter_q]   <= '0;
            end else if (do_fill && victim == WAY_W'(gw)) begin
                valid_mem[gw][w_idx] <= 1'b1;
                tag_mem[gw][w_idx]   <= w_tag;
            end
        end

        always_ff @(posedge aclk) begin
            if (do_fill && victim == WAY_W'(gw)) begin
                for (int b = 0; b < NB_BYTES; b++) begin
                    if (wstrb[b])
                        data_mem[gw][w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Descending scan so the lowest matching way wins.
    always_comb begin
        rd_hit = 1'b0;
        rd_way = '0;
        for (int w = NB_WAYS - 1; w >= 0; w--) begin
            if (valid_mem[w][r_idx] && tag_mem[w][r_idx] == r_tag) begin
                rd_hit = 1'b1;
                rd_way = WAY_W'(w);
            end
        end
    end

    assign rd_line = data_mem[rd_way][r_idx];
    assign rd_word = rd_line[r_word*WLEN +: WLEN];

    always_comb begin
        dup_tag = 1'b0;
        for (int w = 0; w < NB_WAYS; w++) begin
            if (WAY_W'(w) != victim && valid_mem[w][w_idx] && tag_mem[w][w_idx] == w_tag)
                dup_tag = 1'b1;
        end
    end

    // The controller only refills after a miss, so a tag must never live in two ways of a set.
    assert property (@(posedge aclk) disable iff (!aresetn) do_fill |-> !dup_tag);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            rdata_q   <= '0;
            hit_way_q <= '0;
        end else if (srst) begin
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            rdata_q   <= '0;
            hit_way_q <= '0;
        end else begin
            hit_q  <= do_read && rd_hit;
            miss_q <= do_read && !rd_hit;
            if (do_read && rd_hit) begin
                rdata_q   <= rd_word;
                hit_way_q <= rd_way;
            end
        end
    end

    assign hit     = hit_q;
    assign miss    = miss_q;
    assign rdata   = rdata_q;
    assign hit_way = hit_way_q;

endmodule

// File: tb/tb_friscv_cache_ways.sv
// tb/tb_friscv_cache_ways.sv - vector table plus scoreboard bench for friscv_cache_ways
module tb_friscv_cache_ways;

    localparam int WLEN  = 32;
    localparam int AW    = 32;
    localparam int BLK   = 128;
    localparam int DEPTH = 4;
    localparam int WAYS  = 2;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            srst = 1'b0;
    logic            flush_req = 1'b0;
    logic            wen = 1'b0;
    logic            ren = 1'b0;
    logic [AW-1:0]   waddr = '0;
    logic [AW-1:0]   raddr = '0;
    logic [BLK-1:0]  wdata = '0;
    logic [BLK/8-1:0] wstrb = '0;
    logic            ready, hit, miss;
    logic [WLEN-1:0] rdata;
    logic [0:0]      hit_way;

    friscv_cache_ways #(
        .WLEN(WLEN), .ADDR_W(AW), .CACHE_BLOCK_W(BLK), .CACHE_DEPTH(DEPTH), .NB_WAYS(WAYS)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .flush_req(flush_req), .ready(ready),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .ren(ren), .raddr(raddr), .rdata(rdata), .hit(hit), .miss(miss), .hit_way(hit_way)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    int rd_id = 0;

    typedef struct {
        int          id;
        logic        hit;
        logic        miss;
        logic [0:0]  way;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit           fill;
        logic [31:0]  addr;
        logic [127:0] line;
        logic [15:0]  strb;
        bit           exp_hit;
        logic [0:0]   exp_way;
        logic [31:0]  exp_word;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    // Bench model of the held output registers.
    logic [31:0] m_rdata = '0;
    logic [0:0]  m_way = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge aclk);
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("hit#%0d", e.id), {31'd0, hit}, {31'd0, e.hit});
            check($sformatf("miss#%0d", e.id), {31'd0, miss}, {31'd0, e.miss});
            check($sformatf("way#%0d", e.id), {31'd0, hit_way}, {31'd0, e.way});
            check($sformatf("rdata#%0d", e.id), rdata, e.rdata);
        end
    endtask

    task automatic push_quiet();
        exp_t e;
        e.id = rd_id++; e.hit = 1'b0; e.miss = 1'b0; e.way = m_way; e.rdata = m_rdata;
        sb_q.push_back(e);
    endtask

    task automatic do_read(input logic [31:0] a, input bit h, input logic [0:0] w, input logic [31:0] d);
        exp_t e;
        ren = 1'b1; raddr = a;
        if (h) begin m_rdata = d; m_way = w; end
        e.id = rd_id++; e.hit = h; e.miss = !h; e.way = m_way; e.rdata = m_rdata;
        sb_q.push_back(e);
        step();
        ren = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] a, input logic [127:0] l, input logic [15:0] s);
        wen = 1'b1; waddr = a; wdata = l; wstrb = s;
        push_quiet();
        step();
        wen = 1'b0;
    endtask

    task automatic expect_flush_len(input string name);
        int n = 0;
        do begin
            @(posedge aclk);
            #1;
            n++;
        end while (!ready && n < 64);
        check(name, n, DEPTH);
    endtask

    function automatic logic [127:0] mkline(input logic [15:0] t);
        return {t, 16'h0003, t, 16'h0002, t, 16'h0001, t, 16'h0000};
    endfunction

    function automatic void vf(input logic [31:0] a, input logic [127:0] l, input logic [15:0] s);
        vec_t v;
        v.fill = 1'b1; v.addr = a; v.line = l; v.strb = s;
        v.exp_hit = 1'b0; v.exp_way = '0; v.exp_word = '0;
        vecs.push_back(v);
    endfunction

    function automatic void vr(input logic [31:0] a, input bit h, input logic [0:0] w, input logic [31:0] d);
        vec_t v;
        v.fill = 1'b0; v.addr = a; v.line = '0; v.strb = '0;
        v.exp_hit = h; v.exp_way = w; v.exp_word = d;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [127:0] l1;
        logic [31:0]  miss_addrs[7];
        l1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        // index 0: fill/read, two-way conflict, eviction, pointer wrap
        vf(32'h1000, l1, 16'hFFFF);
        vr(32'h1008, 1, 0, 32'h33333333);
        vr(32'h1000, 1, 0, 32'h11111111);
        vf(32'h2000, mkline(16'hBBBB), 16'hFFFF);
        vr(32'h200C, 1, 1, 32'hBBBB0003);
        vr(32'h1004, 1, 0, 32'h22222222);
        vf(32'h3000, mkline(16'hCCCC), 16'hFFFF);
        vr(32'h1000, 0, 0, 32'h0);
        vr(32'h2000, 1, 1, 32'hBBBB0000);
        vr(32'h3008, 1, 0, 32'hCCCC0002);
        vf(32'h4000, mkline(16'hDDDD), 16'hFFFF);
        vr(32'h2000, 0, 0, 32'h0);
        vr(32'h4004, 1, 1, 32'hDDDD0001);
        vr(32'h3000, 1, 0, 32'hCCCC0000);
        // index 1: byte strobes land in the same way on its next turn
        vf(32'h1010, mkline(16'hEEEE), 16'hFFFF);
        vf(32'h2010, mkline(16'hFFFF), 16'hFFFF);
        vf(32'h1010, {96'h0, 32'hDEADBEEF}, 16'h000F);
        vr(32'h1010, 1, 0, 32'hDEADBEEF);
        vr(32'h1014, 1, 0, 32'hEEEE0001);
        vr(32'h1018, 1, 0, 32'hEEEE0002);
        vr(32'h101C, 1, 0, 32'hEEEE0003);
        vr(32'h2014, 1, 1, 32'hFFFF0001);

        repeat (3) @(posedge aclk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_miss", {31'd0, miss}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_way", {31'd0, hit_way}, 32'd0);
        aresetn = 1'b1;
        expect_flush_len("init_len");

        do_read(32'h0000_0010, 0, 0, 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].fill) do_fill(vecs[i].addr, vecs[i].line, vecs[i].strb);
            else do_read(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_way, vecs[i].exp_word);
        end

        // wen+ren together: fill wins, read dropped
        wen = 1'b1; waddr = 32'h1020; wdata = mkline(16'h7777); wstrb = 16'hFFFF;
        ren = 1'b1; raddr = 32'h3000;
        push_quiet();
        step();
        wen = 1'b0; ren = 1'b0;
        do_read(32'h1020, 1, 0, 32'h77770000);
        do_fill(32'h2020, mkline(16'h8888), 16'hFFFF);

        // flush_req+wen together: fill dropped, then everything misses
        flush_req = 1'b1; wen = 1'b1; waddr = 32'h5020; wdata = mkline(16'h9999); wstrb = 16'hFFFF;
        push_quiet();
        step();
        flush_req = 1'b0; wen = 1'b0;
        check("flush_ready_low", {31'd0, ready}, 32'd0);
        expect_flush_len("flush_len");
        miss_addrs = '{32'h3000, 32'h4000, 32'h1010, 32'h2010, 32'h1020, 32'h2020, 32'h5020};
        foreach (miss_addrs[i]) do_read(miss_addrs[i], 0, 0, 32'h0);
        do_fill(32'h5020, {96'h0, 32'hCAFEF00D}, 16'h000F);
        do_read(32'h5020, 1, 0, 32'hCAFEF00D);
        do_read(32'h5024, 1, 0, 32'h77770001);

        // srst mid-flush restarts the walk and clears outputs
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        check("srst_rdata", rdata, 32'd0);
        check("srst_ready", {31'd0, ready}, 32'd0);
        m_rdata = '0; m_way = '0;
        expect_flush_len("srst_flush_len");
        do_read(32'h5020, 0, 0, 32'h0);

        // aresetn asserted right after a hit response
        do_fill(32'h1030, mkline(16'hAAAA), 16'hFFFF);
        do_fill(32'h2030, mkline(16'h5555), 16'hFFFF);
        do_read(32'h2034, 1, 1, 32'h55550001);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_rdata", rdata, 32'd0);
        check("async_way", {31'd0, hit_way}, 32'd0);
        check("async_ready", {31'd0, ready}, 32'd0);
        m_rdata = '0; m_way = '0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        expect_flush_len("reinit_len");
        do_read(32'h1034, 0, 0, 32'h0);
        do_fill(32'h3030, mkline(16'h3333), 16'hFFFF);
        do_read(32'h3038, 1, 0, 32'h33330002);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
